// File: rtl/instr_mem_loader.sv
// LC2K instruction memory loader.
// Assembles big-endian words from a byte stream and writes them from addr 0.
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int WLW = ADDR_WIDTH + 1;
  localparam logic [16:0] DEPTH = 17'(1 << ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_n;

  logic [1:0]     idx;
  logic [7:0]     hdr_hi;
  logic [15:0]    cnt;
  logic [23:0]    sh;
  logic [WLW-1:0] wl;

  logic           xfer;
  logic [15:0]    hdr_word;
  logic [WLW-1:0] wl_inc;
  logic           last_word;
  logic           restart;

  assign xfer      = in_valid && in_ready;
  assign hdr_word  = {hdr_hi, in_data};
  assign wl_inc    = wl + 1'b1;
  assign last_word = ({{(16-WLW){1'b0}}, wl_inc} == cnt);
  assign restart   = start &&
                     (state == S_IDLE || state == S_DONE || state == S_ERR);

  assign in_ready     = (state == S_HDR) || (state == S_DATA);
  assign wr_en        = (state == S_WRITE);
  assign cpu_hold     = (state != S_DONE);
  assign done         = (state == S_DONE);
  assign error        = (state == S_ERR);
  assign words_loaded = wl;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (start) state_n = S_HDR;
      S_HDR: begin
        if (xfer && idx == 2'd1) begin
          if (hdr_word == 16'd0)
            state_n = S_DONE;
          else if ({1'b0, hdr_word} > DEPTH)
            state_n = S_ERR;
          else
            state_n = S_DATA;
        end
      end
      S_DATA:  if (xfer && idx == 2'd3) state_n = S_WRITE;
      S_WRITE: state_n = last_word ? S_DONE : S_DATA;
      S_DONE:  if (start) state_n = S_HDR;
      S_ERR:   if (start) state_n = S_HDR;
      default: state_n = S_IDLE;
    endcase
  end

  // Byte assembly, header capture, write port and word counter
  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= 2'd0;
      hdr_hi  <= 8'd0;
      cnt     <= 16'd0;
      sh      <= 24'd0;
      wl      <= '0;
      wr_addr <= '0;
      wr_data <= 32'd0;
    end else begin
      if (restart) begin
        idx <= 2'd0;
        wl  <= '0;
      end
      if (xfer) begin
        idx <= idx + 2'd1;
        if (state == S_HDR) begin
          if (idx == 2'd0) begin
            hdr_hi <= in_data;
          end else begin
            cnt <= hdr_word;
            idx <= 2'd0;
          end
        end else begin
          if (idx == 2'd3) begin
            wr_data <= {sh, in_data};
            wr_addr <= wl[ADDR_WIDTH-1:0];
          end else begin
            sh <= {sh[15:0], in_data};
          end
        end
      end
      if (state == S_WRITE) wl <= wl_inc;
    end
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Writer side of the LC2K instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each completed word is issued as a one-cycle write to the instruction memory write port at sequential addresses from 0. While loading, it holds the CPU in reset and releases it when the program is fully written.

Parameters:
ADDR_WIDTH, 4, instruction memory address width; depth = 2**ADDR_WIDTH words (16).

Ports:
clk  input  1  system clock; all logic acts on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR
in_data  input  8  stream byte
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  loader accepts a byte this cycle; transfer when in_valid && in_ready
wr_en  output  1  instruction memory write strobe, one cycle per word
wr_addr  output  ADDR_WIDTH  word address for the write
wr_data  output  32  instruction word
cpu_hold  output  1  hold the CPU in reset (pcCurrent held at 0)
done  output  1  program fully loaded
error  output  1  header word count exceeds depth
words_loaded  output  ADDR_WIDTH+1  count of words written so far

Behaviour:
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0, words_loaded=0. State becomes IDLE and the byte index clears.
- Reset mid-load aborts immediately. Already-written memory contents are not cleared.
- IDLE: in_ready=0. start -> HDR with words_loaded=0 and byte index=0.
- HDR: in_ready=1. Accepts 2 bytes forming a 16-bit count N, high byte first.
  - After the second byte: N==0 -> DONE; N > 2**ADDR_WIDTH -> ERROR; otherwise -> DATA.
- DATA: in_ready=1. Accepts bytes into a shift register, first byte into bits [31:24] (big-endian).
  - The 4th accepted byte -> WRITE on the next edge.
  - in_valid low stalls with no state change. Partial words are retained.
- WRITE (one cycle): in_ready=0, wr_en=1, wr_addr=words_loaded[ADDR_WIDTH-1:0], wr_data=assembled word.
  - On exit, words_loaded increments.
  - words_loaded==N after increment -> DONE; else -> DATA.
  - Latency: 4th byte accepted at edge t means wr_en is high in cycle t+1.
- wr_en is high only in WRITE. wr_addr and wr_data hold their last values otherwise.
- DONE: done=1, cpu_hold=0, in_ready=0. Extra stream bytes are not accepted. start -> HDR, which reloads: done=0, cpu_hold=1 in the next cycle.
- ERROR: error=1 (sticky), cpu_hold=1, in_ready=0. Only start or reset leave it; start -> HDR and clears error.
- start in HDR, DATA or WRITE is ignored; the load continues.
- cpu_hold=1 in every state except DONE, including IDLE after reset.
- words_loaded never exceeds N. A count of exactly 2**ADDR_WIDTH is legal: the last address is 2**ADDR_WIDTH-1, and words_loaded reaches 2**ADDR_WIDTH with no wrap.
- No byte is dropped or duplicated. A transfer is counted only when in_valid && in_ready at the clock edge.

Test Plan:
- Reset, then start with header 00 07 and the 28 bytes of the 7 jalrTest words. The first word is bytes 00 82 00 07. Required: 7 wr_en pulses at addrs 0..6; addr0 data 0x00820007 (8519687); addr6 data 0x01800000 (25165824); then done=1, cpu_hold=0, words_loaded=7.
- Same load with in_valid dropped for 3 cycles between bytes 2 and 3 of word 1. Required: identical writes; wr_en asserted exactly one cycle after the 4th byte of each word.
- Header 00 00. Required: DONE two edges after start, no wr_en, words_loaded=0.
- Header 00 11 (17 > 16). Required: error=1, cpu_hold=1, in_ready=0, no writes; a subsequent start clears error.
- Header 00 10 with 16 words. Required: last write at addr 15, words_loaded=16, done=1.
- Assert reset after 2 words of a 5-word load, then start again. Required: all outputs return to reset values; the second load rewrites from addr 0.
